rsa_modexp_ctrl: RTL and testbench

Sequencer for the 256-bit RSA modular-exponentiation path. It runs left-to-right square-and-multiply over a 32-bit exponent, issuing one Montgomery multiplication at a time to an external shared multiplier core through a start/done handshake. It also handles conversion into and out of the Montgomery domain, latches the final result and raises `end_flag`. It sits between the RSA top level, which supplies operands, and the Montgomery multiplier datapath.

---
 rtl/rsa_pkg.sv | 27 ++
 rtl/rsa_mm_opmux.sv | 31 +++
 rtl/rsa_modexp_ctrl.sv | 131 +++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared widths, FSM states and multiplier op selects for the RSA modexp path
package rsa_pkg;
  localparam int RSA_W = 256;
  localparam int EXP_W = 32;
  localparam int MP_W  = 32;
  localparam int IDX_W = $clog2(EXP_W);

  typedef enum logic [2:0] {
    IDLE, CONV_X, CONV_A, SQR, MUL, FROM_M, DONE
  } modexp_state_t;

  typedef enum logic [2:0] {
    OP_CONV_X, OP_CONV_A, OP_SQR, OP_MUL, OP_FROM_M
  } mm_op_t;

  function automatic mm_op_t state_op(input modexp_state_t s);
    mm_op_t op;
    case (s)
      CONV_A:  op = OP_CONV_A;
      SQR:     op = OP_SQR;
      MUL:     op = OP_MUL;
      FROM_M:  op = OP_FROM_M;
      default: op = OP_CONV_X;
    endcase
    return op;
  endfunction
endpackage

// File: rtl/rsa_mm_opmux.sv
// rtl/rsa_mm_opmux.sv - selects Montgomery multiplier operands for the current op
module rsa_mm_opmux
  import rsa_pkg::*;
(
  input  logic             en,
  input  mm_op_t           op,
  input  logic [RSA_W-1:0] x_in,
  input  logic [RSA_W-1:0] r2,
  input  logic [RSA_W-1:0] acc,
  input  logic [RSA_W-1:0] xm,
  output logic [RSA_W-1:0] a,
  output logic [RSA_W-1:0] b
);
  localparam logic [RSA_W-1:0] ONE = RSA_W'(1);

  // Operands read as zero whenever no operation is in progress
  always_comb begin
    a = '0;
    b = '0;
    if (en) begin
      case (op)
        OP_CONV_X: begin a = x_in; b = r2;  end
        OP_CONV_A: begin a = ONE;  b = r2;  end
        OP_SQR:    begin a = acc;  b = acc; end
        OP_MUL:    begin a = acc;  b = xm;  end
        OP_FROM_M: begin a = acc;  b = ONE; end
        default:   begin a = '0;   b = '0;  end
      endcase
    end
  end
endmodule

// File: rtl/rsa_modexp_ctrl.sv
// rtl/rsa_modexp_ctrl.sv - square-and-multiply sequencer for the shared Montgomery multiplier
// Define RSA_CONST_TIME_EN to run a multiply after every square (exponent-independent timing).
module rsa_modexp_ctrl
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [EXP_W-1:0] pow,
  input  logic [RSA_W-1:0] indata,
  input  logic [RSA_W-1:0] modulos,
  input  logic [MP_W-1:0]  mp,
  input  logic [RSA_W-1:0] r2,
  output logic [RSA_W-1:0] outdata,
  output logic             end_flag,
  output logic             busy,
  output logic             mm_start,
  output logic [RSA_W-1:0] mm_a,
  output logic [RSA_W-1:0] mm_b,
  output logic [RSA_W-1:0] mm_n,
  output logic [MP_W-1:0]  mm_mp,
  input  logic             mm_done,
  input  logic [RSA_W-1:0] mm_res
);
  modexp_state_t    state;
  logic             waiting;
  logic [EXP_W-1:0] pow_r;
  logic [RSA_W-1:0] x_r;
  logic [RSA_W-1:0] r2_r;
  logic [RSA_W-1:0] acc;
  logic [RSA_W-1:0] xm;
  logic [IDX_W-1:0] idx;
  logic             op_done;
  mm_op_t           op;

  assign op_done = waiting && mm_done;
  assign op      = state_op(state);

  rsa_mm_opmux u_opmux (
    .en   (busy),
    .op   (op),
    .x_in (x_r),
    .r2   (r2_r),
    .acc  (acc),
    .xm   (xm),
    .a    (mm_a),
    .b    (mm_b)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      waiting  <= 1'b0;
      mm_start <= 1'b0;
      busy     <= 1'b0;
      end_flag <= 1'b0;
      outdata  <= '0;
      mm_n     <= '0;
      mm_mp    <= '0;
      pow_r    <= '0;
      x_r      <= '0;
      r2_r     <= '0;
      acc      <= '0;
      xm       <= '0;
      idx      <= '0;
    end else begin
      mm_start <= 1'b0;
      if (mm_start) waiting <= 1'b1;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pow_r    <= pow;
            x_r      <= indata;
            mm_n     <= modulos;
            mm_mp    <= mp;
            r2_r     <= r2;
            idx      <= IDX_W'(EXP_W - 1);
            end_flag <= 1'b0;
            busy     <= 1'b1;
            mm_start <= 1'b1;
            state    <= CONV_X;
          end
        end
        default: begin
          // Every completed op launches the next one, except the final conversion
          if (op_done) begin
            waiting  <= 1'b0;
            mm_start <= 1'b1;
            case (state)
              CONV_X: begin xm  <= mm_res; state <= CONV_A; end
              CONV_A: begin acc <= mm_res; state <= SQR;    end
              SQR: begin
                acc <= mm_res;
`ifdef RSA_CONST_TIME_EN
                state <= MUL;
`else
                if (pow_r[idx]) state <= MUL;
                else if (idx == '0) state <= FROM_M;
                else begin
                  idx   <= idx - 1'b1;
                  state <= SQR;
                end
`endif
              end
              MUL: begin
`ifdef RSA_CONST_TIME_EN
                if (pow_r[idx]) acc <= mm_res;
`else
                acc <= mm_res;
`endif
                if (idx == '0) state <= FROM_M;
                else begin
                  idx   <= idx - 1'b1;
                  state <= SQR;
                end
              end
              FROM_M: begin
                outdata  <= mm_res;
                end_flag <= 1'b1;
                busy     <= 1'b0;
                mm_start <= 1'b0;
                state    <= DONE;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// tb/tb_rsa_modexp_ctrl.sv - scoreboard bench for rsa_modexp_ctrl with a behavioural Montgomery multiplier
module tb_rsa_modexp_ctrl;
  import rsa_pkg::*;

  localparam logic [RSA_W-1:0] BIG_N = 256'h2523648240000001ba344d80000000086121000000000013a700000000000013;
  localparam logic [RSA_W-1:0] BIG_X = 256'h1d33e562bfffffe98b58107fffffff931152ffffffffff0084ffffffffffff09;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [EXP_W-1:0] pow = '0;
  logic [RSA_W-1:0] indata = '0;
  logic [RSA_W-1:0] modulos = '0;
  logic [MP_W-1:0]  mp = '0;
  logic [RSA_W-1:0] r2 = '0;
  logic [RSA_W-1:0] outdata;
  logic             end_flag;
  logic             busy;
  logic             mm_start;
  logic [RSA_W-1:0] mm_a;
  logic [RSA_W-1:0] mm_b;
  logic [RSA_W-1:0] mm_n;
  logic [MP_W-1:0]  mm_mp;
  logic             mm_done = 1'b0;
  logic [RSA_W-1:0] mm_res = '0;

  always #5 clk = ~clk;

  rsa_modexp_ctrl dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .pow      (pow),
    .indata   (indata),
    .modulos  (modulos),
    .mp       (mp),
    .r2       (r2),
    .outdata  (outdata),
    .end_flag (end_flag),
    .busy     (busy),
    .mm_start (mm_start),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .mm_n     (mm_n),
    .mm_mp    (mm_mp),
    .mm_done  (mm_done),
    .mm_res   (mm_res)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [RSA_W-1:0] got, input logic [RSA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [RSA_W-1:0] mod_mul(input logic [RSA_W-1:0] a, input logic [RSA_W-1:0] b,
                                               input logic [RSA_W-1:0] n);
    logic [2*RSA_W-1:0] p;
    p = (2*RSA_W)'(a) * (2*RSA_W)'(b);
    return RSA_W'(p % (2*RSA_W)'(n));
  endfunction

  function automatic logic [RSA_W-1:0] mod_exp(input logic [RSA_W-1:0] x, input logic [EXP_W-1:0] p,
                                               input logic [RSA_W-1:0] n);
    logic [RSA_W-1:0] r;
    r = RSA_W'(1);
    for (int i = EXP_W - 1; i >= 0; i--) begin
      r = mod_mul(r, r, n);
      if (p[i]) r = mod_mul(r, x, n);
    end
    return r;
  endfunction

  function automatic logic [RSA_W-1:0] calc_r2(input logic [RSA_W-1:0] n);
    logic [2*RSA_W:0] big;
    big = '0;
    big[2*RSA_W] = 1'b1;
    return RSA_W'(big % (2*RSA_W+1)'(n));
  endfunction

  function automatic logic [MP_W-1:0] calc_mp(input logic [RSA_W-1:0] n);
    logic [MP_W-1:0] n32;
    logic [MP_W-1:0] inv;
    n32 = n[MP_W-1:0];
    inv = n32;
    for (int i = 0; i < 5; i++) inv = inv * (MP_W'(2) - n32 * inv);
    return MP_W'(0) - inv;
  endfunction

  // Bit-serial Montgomery product a*b*2^-256 mod n
  function automatic logic [RSA_W-1:0] mont(input logic [RSA_W-1:0] a, input logic [RSA_W-1:0] b,
                                            input logic [RSA_W-1:0] n);
    logic [RSA_W+1:0] t;
    t = '0;
    for (int i = 0; i < RSA_W; i++) begin
      if (a[i]) t = t + (RSA_W+2)'(b);
      if (t[0]) t = t + (RSA_W+2)'(n);
      t = t >> 1;
    end
    if (t >= (RSA_W+2)'(n)) t = t - (RSA_W+2)'(n);
    return RSA_W'(t);
  endfunction

  int               lat = 5;
  int               cnt = 0;
  int               starts = 0;
  logic             inject = 1'b0;
  logic [RSA_W-1:0] pend = '0;
  logic [RSA_W-1:0] a_s = '0;
  logic [RSA_W-1:0] b_s = '0;
  logic [RSA_W-1:0] exp_n = '0;
  logic [MP_W-1:0]  exp_mp = '0;

  always @(negedge clk) begin
    mm_done = 1'b0;
    if (!rstn) cnt = 0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        mm_done = 1'b1;
        mm_res  = pend;
        check_val("mm_a_stable", mm_a, a_s);
        check_val("mm_b_stable", mm_b, b_s);
      end
    end
    if (inject) begin
      mm_done = 1'b1;
      mm_res  = {8{32'hdeadbeef}};
    end
    if (mm_start) begin
      starts++;
      a_s  = mm_a;
      b_s  = mm_b;
      pend = mont(mm_a, mm_b, mm_n);
      cnt  = lat;
      check_val("mm_n", mm_n, exp_n);
      check_val("mm_mp", RSA_W'(mm_mp), RSA_W'(exp_mp));
    end
  end

  typedef struct {
    logic [RSA_W-1:0] res;
    int               ops;
    int               cyc;
  } exp_t;

  exp_t sb[$];

  task automatic drive_start(input logic [RSA_W-1:0] n, input logic [RSA_W-1:0] x,
                             input logic [EXP_W-1:0] p, input int l);
    lat    = l;
    exp_n  = n;
    exp_mp = calc_mp(n);
    @(negedge clk);
    modulos = n;
    indata  = x;
    pow     = p;
    mp      = exp_mp;
    r2      = calc_r2(n);
    start   = 1'b1;
    starts  = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_case(input string tag, input logic [RSA_W-1:0] n, input logic [RSA_W-1:0] x,
                          input logic [EXP_W-1:0] p, input int l, input bit poke);
    exp_t e;
    int   k;
    bit   seen;
    e.res = mod_exp(x, p, n);
`ifdef RSA_CONST_TIME_EN
    e.ops = 3 + 2 * EXP_W;
`else
    e.ops = 3 + EXP_W + $countones(p);
`endif
    e.cyc = e.ops * (l + 1) + 1;
    sb.push_back(e);
    drive_start(n, x, p, l);
    seen = 1'b0;
    for (k = 1; k < 4000; k++) begin
      if (poke && k == 20) begin
        start  = 1'b1;
        indata = x ^ RSA_W'(1);
        pow    = ~p;
      end else begin
        start = 1'b0;
      end
      if (end_flag) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    check_val({tag, "_end_flag"}, RSA_W'(seen), RSA_W'(1));
    check_val({tag, "_outdata"}, outdata, e.res);
    check_val({tag, "_latency"}, RSA_W'(k), RSA_W'(e.cyc));
    check_val({tag, "_ops"}, RSA_W'(starts), RSA_W'(e.ops));
    check_val({tag, "_busy"}, RSA_W'(busy), '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_outdata"}, outdata, '0);
    check_val({tag, "_end_flag"}, RSA_W'(end_flag), '0);
    check_val({tag, "_busy"}, RSA_W'(busy), '0);
    check_val({tag, "_mm_start"}, RSA_W'(mm_start), '0);
    check_val({tag, "_mm_a"}, mm_a, '0);
    check_val({tag, "_mm_b"}, mm_b, '0);
    check_val({tag, "_mm_n"}, mm_n, '0);
    check_val({tag, "_mm_mp"}, RSA_W'(mm_mp), '0);
  endtask

  task automatic spurious_done(input string tag, input logic [RSA_W-1:0] out_exp, input logic flag_exp);
    @(posedge clk);
    inject = 1'b1;
    @(posedge clk);
    inject = 1'b0;
    @(negedge clk);
    check_val({tag, "_outdata"}, outdata, out_exp);
    check_val({tag, "_end_flag"}, RSA_W'(end_flag), RSA_W'(flag_exp));
    check_val({tag, "_busy"}, RSA_W'(busy), '0);
    check_val({tag, "_mm_start"}, RSA_W'(mm_start), '0);
  endtask

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    run_case("pow10", RSA_W'(1019), RSA_W'(2), 32'd10, 5, 1'b0);
    check_val("pow10_value", outdata, RSA_W'(5));
    spurious_done("done_spurious", RSA_W'(5), 1'b1);

    run_case("pow0", RSA_W'(1019), RSA_W'(123), 32'd0, 5, 1'b0);
    check_val("pow0_value", outdata, RSA_W'(1));

    run_case("big_l5", BIG_N, BIG_X, 32'd3272068392, 5, 1'b0);
    run_case("big_l1", BIG_N, BIG_X, 32'd3272068392, 1, 1'b0);
    run_case("mid_start", BIG_N, BIG_X, 32'h1234abcd, 3, 1'b1);
    run_case("msb_lsb", RSA_W'(1019), RSA_W'(7), 32'h80000001, 2, 1'b0);

    // Reset while the first square is in flight
    drive_start(RSA_W'(1019), RSA_W'(2), 32'd10, 5);
    for (k = 0; k < 200 && starts < 3; k++) @(negedge clk);
    check_val("sqr_reached", RSA_W'(starts >= 3), RSA_W'(1));
    @(negedge clk);
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    spurious_done("idle_spurious", '0, 1'b0);

    run_case("after_reset", RSA_W'(1019), RSA_W'(2), 32'd10, 5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
